// File: rtl/event_data_packer_pkg.sv
// Shared definitions for the event data packer: word tags, trailer flag
// positions, FSM state encoding and a trailer-word helper.
package event_data_packer_pkg;

  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hAA55;
  localparam logic [7:0]  TRL_TAG         = 8'hEE;

  // Bit positions inside the trailer flag byte.
  localparam int FLAG_ABORT   = 0;
  localparam int FLAG_DROPPED = 1;
  localparam int FLAG_ODD_PAD = 2;

  // ST_TS is only reachable when the timestamp word is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TS   = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_TRL  = 3'd4
  } state_t;

  function automatic logic [31:0] trailer_word(input logic [7:0]  flags,
                                               input logic [15:0] count);
    return {TRL_TAG, flags, count};
  endfunction

endpackage

// File: rtl/event_packer_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on q
// whenever empty is low; rd_en pops it. fill_level counts stored words.
module event_packer_fifo_fwft #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  output logic [31:0]           q,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;

  // A pop on an empty FIFO, or a push into a full one, is simply ignored.
  assign push = wr_en && (count != DEPTH_W);
  assign pop  = rd_en && (count != '0);

  // Storage array write.
  // NOTE: the storage array has no reset; only pointers and count are
  // reset, which flushes the FIFO without a reset fan-out to every word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty      = (count == '0);
  assign q          = empty ? '0 : mem[rd_ptr];
  assign fill_level = count;

endmodule

// File: rtl/event_data_packer.sv
// Packs framed 16-bit samples into 32-bit words wrapped by a header and a
// trailer, and buffers them in an FWFT FIFO drained by the control interface.
// Optional build macro TIMESTAMP_EN adds a timestamp word after the header.
module event_data_packer
  import event_data_packer_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] HDR_TAG    = HDR_TAG_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                ENABLE,
  input  logic                CLR_STATUS,
  input  logic                FRAME_START,
  input  logic [15:0]         SAMPLE,
  input  logic                SAMPLE_VALID,
  input  logic                FRAME_END,
  output logic                BUSY,
  output logic [31:0]         DATA_FIFO_Q,
  output logic                DATA_FIFO_EMPTY,
  input  logic                DATA_FIFO_RDREQ,
  output logic [DEPTH_LOG2:0] FILL_LEVEL,
  output logic [15:0]         FRAME_DROP_CNT,
  output logic                OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W  = (DEPTH_LOG2 + 1)'(DEPTH);
  // One slot is always held back so the trailer can be written.
  localparam logic [DEPTH_LOG2:0] DATA_MIN = (DEPTH_LOG2 + 1)'(2);
`ifdef TIMESTAMP_EN
  localparam logic [DEPTH_LOG2:0] HDR_MIN  = (DEPTH_LOG2 + 1)'(4);
`else
  localparam logic [DEPTH_LOG2:0] HDR_MIN  = (DEPTH_LOG2 + 1)'(3);
`endif

  state_t       state;
  logic [15:0]  frame_number;
  logic [15:0]  word_count;
  logic [7:0]   flags;
  logic [15:0]  half;
  logic         half_valid;
  logic         busy;
  logic [15:0]  drop_cnt;
  logic         overflow;

  logic [DEPTH_LOG2:0] free;
  logic         space_data;
  logic         open_req;
  logic         hdr_ok;
  logic         frame_reject;
  logic         pair_ready;
  logic         frame_close;
  logic         pending_after;
  logic         word_drop;
  logic         wr_en;
  logic [31:0]  wr_data;

`ifdef TIMESTAMP_EN
  logic [31:0]  ts_cnt;
  logic [31:0]  ts_latched;
`endif

  // Space is judged on the occupancy before this cycle's write and pop.
  assign free          = DEPTH_W - FILL_LEVEL;
  assign space_data    = (free >= DATA_MIN) && (word_count != 16'hFFFF);
  assign open_req      = (state == ST_IDLE) && FRAME_START && ENABLE;
  assign hdr_ok        = open_req && (free >= HDR_MIN);
  assign frame_reject  = open_req && !(free >= HDR_MIN);
  assign pair_ready    = (state == ST_DATA) && SAMPLE_VALID && half_valid;
  assign frame_close   = (state == ST_DATA) && (FRAME_END || FRAME_START);
  assign pending_after = SAMPLE_VALID ? !half_valid : half_valid;
  assign word_drop     = (pair_ready || (state == ST_PAD)) && !space_data;

  // Select the single FIFO write of this cycle from the current state.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (hdr_ok) begin
          wr_en   = 1'b1;
          wr_data = {HDR_TAG, frame_number};
        end
      end
`ifdef TIMESTAMP_EN
      ST_TS: begin
        wr_en   = 1'b1;
        wr_data = ts_latched;
      end
`endif
      ST_DATA: begin
        if (pair_ready && space_data) begin
          wr_en   = 1'b1;
          wr_data = {half, SAMPLE};
        end
      end
      ST_PAD: begin
        if (space_data) begin
          wr_en   = 1'b1;
          wr_data = {half, 16'h0000};
        end
      end
      ST_TRL: begin
        wr_en   = 1'b1;
        wr_data = trailer_word(flags, word_count);
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

`ifdef TIMESTAMP_EN
  // Free-running timestamp, captured when a frame is admitted.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_cnt     <= '0;
      ts_latched <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (hdr_ok) ts_latched <= ts_cnt;
    end
  end
`endif

  // Frame FSM with its registered BUSY flag and sticky status counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      frame_number <= '0;
      word_count   <= '0;
      flags        <= '0;
      half         <= '0;
      half_valid   <= 1'b0;
      busy         <= 1'b0;
      drop_cnt     <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_ok) begin
            frame_number <= frame_number + 1'b1;
            word_count   <= '0;
            flags        <= '0;
            half_valid   <= 1'b0;
`ifdef TIMESTAMP_EN
            state        <= ST_TS;
            busy         <= 1'b1;
`else
            state        <= ST_DATA;
            busy         <= 1'b0;
`endif
          end
        end
        ST_TS: begin
          state <= ST_DATA;
          busy  <= 1'b0;
        end
        ST_DATA: begin
          if (SAMPLE_VALID) begin
            if (!half_valid) begin
              half       <= SAMPLE;
              half_valid <= 1'b1;
            end else begin
              half_valid <= 1'b0;
              if (space_data) word_count <= word_count + 1'b1;
              else            flags[FLAG_DROPPED] <= 1'b1;
            end
          end
          if (frame_close) begin
            if (FRAME_START) flags[FLAG_ABORT] <= 1'b1;
            state <= pending_after ? ST_PAD : ST_TRL;
            busy  <= 1'b1;
          end
        end
        ST_PAD: begin
          if (space_data) word_count <= word_count + 1'b1;
          else            flags[FLAG_DROPPED] <= 1'b1;
          flags[FLAG_ODD_PAD] <= 1'b1;
          half_valid          <= 1'b0;
          state               <= ST_TRL;
        end
        ST_TRL: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A same-cycle clear takes priority over any new loss event.
      if (CLR_STATUS) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (frame_reject && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
        if (frame_reject || word_drop) overflow <= 1'b1;
      end
    end
  end

  event_packer_fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (DATA_FIFO_RDREQ),
    .q          (DATA_FIFO_Q),
    .empty      (DATA_FIFO_EMPTY),
    .fill_level (FILL_LEVEL)
  );

  assign BUSY           = busy;
  assign FRAME_DROP_CNT = drop_cnt;
  assign OVERFLOW       = overflow;

endmodule

// File: tb/tb_event_data_packer.sv
// Directed bench for event_data_packer built with an 8-word FIFO.
module tb_event_data_packer;

  localparam int DL2 = 3;

  logic           CLK = 1'b0;
  logic           RESET_N;
  logic           ENABLE;
  logic           CLR_STATUS;
  logic           FRAME_START;
  logic [15:0]    SAMPLE;
  logic           SAMPLE_VALID;
  logic           FRAME_END;
  logic           BUSY;
  logic [31:0]    DATA_FIFO_Q;
  logic           DATA_FIFO_EMPTY;
  logic           DATA_FIFO_RDREQ;
  logic [DL2:0]   FILL_LEVEL;
  logic [15:0]    FRAME_DROP_CNT;
  logic           OVERFLOW;

  int total = 0;
  int bad   = 0;

  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  event_data_packer #(.DEPTH_LOG2(DL2)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .ENABLE          (ENABLE),
    .CLR_STATUS      (CLR_STATUS),
    .FRAME_START     (FRAME_START),
    .SAMPLE          (SAMPLE),
    .SAMPLE_VALID    (SAMPLE_VALID),
    .FRAME_END       (FRAME_END),
    .BUSY            (BUSY),
    .DATA_FIFO_Q     (DATA_FIFO_Q),
    .DATA_FIFO_EMPTY (DATA_FIFO_EMPTY),
    .DATA_FIFO_RDREQ (DATA_FIFO_RDREQ),
    .FILL_LEVEL      (FILL_LEVEL),
    .FRAME_DROP_CNT  (FRAME_DROP_CNT),
    .OVERFLOW        (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Record every word popped at the next rising edge.
  always @(negedge CLK) begin
    if (RESET_N && DATA_FIFO_RDREQ && !DATA_FIFO_EMPTY) got.push_back(DATA_FIFO_Q);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic fs, input logic sv, input logic [15:0] s, input logic fe);
    FRAME_START  = fs;
    SAMPLE_VALID = sv;
    SAMPLE       = s;
    FRAME_END    = fe;
    tick();
    FRAME_START  = 1'b0;
    SAMPLE_VALID = 1'b0;
    FRAME_END    = 1'b0;
  endtask

  task automatic drain();
    DATA_FIFO_RDREQ = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 24 && !DATA_FIFO_EMPTY; i++) tick();
    check("drain_empty", 32'(DATA_FIFO_EMPTY), 32'd1);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    RESET_N = 1'b0; ENABLE = 1'b1; CLR_STATUS = 1'b0;
    FRAME_START = 1'b0; SAMPLE = '0; SAMPLE_VALID = 1'b0; FRAME_END = 1'b0;
    DATA_FIFO_RDREQ = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_empty", 32'(DATA_FIFO_EMPTY), 32'd1);
    check("rst_fill",  32'(FILL_LEVEL),      32'd0);
    check("rst_q",     DATA_FIFO_Q,          32'd0);
    check("rst_busy",  32'(BUSY),            32'd0);
    check("rst_drop",  32'(FRAME_DROP_CNT),  32'd0);
    check("rst_ovf",   32'(OVERFLOW),        32'd0);
    RESET_N = 1'b1;
    tick();

    // Even frame, reads running throughout
    DATA_FIFO_RDREQ = 1'b1;
    drive(1, 0, 16'h0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 1, 16'(i), 0);
    drive(0, 0, 16'h0, 1);
    drain();
    exp_q = '{32'hAA550000, 32'h00010002, 32'h00030004, 32'hEE000002};
    compare_words("even");

    // Odd frame: pad word and ODD_PAD flag
    drive(1, 0, 16'h0, 0);
    drive(0, 1, 16'h1111, 0);
    drive(0, 1, 16'h2222, 0);
    drive(0, 1, 16'h3333, 0);
    drive(0, 0, 16'h0, 1);
    check("pad_busy", 32'(BUSY), 32'd1);
    drain();
    exp_q = '{32'hAA550001, 32'h11112222, 32'h33330000, 32'hEE040002};
    compare_words("odd");

    // Fill without reads, then a frame that cannot be admitted
    DATA_FIFO_RDREQ = 1'b0;
    drive(1, 0, 16'h0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 16'(i), 0);
    drive(0, 0, 16'h0, 1);
    repeat (2) tick();
    check("full_fill", 32'(FILL_LEVEL), 32'd6);
    check("full_ovf0", 32'(OVERFLOW),   32'd0);
    drive(1, 0, 16'h0, 0);
    check("rej_drop", 32'(FRAME_DROP_CNT), 32'd1);
    check("rej_ovf",  32'(OVERFLOW),       32'd1);
    for (int i = 1; i <= 8; i++) drive(0, 1, 16'(i), 0);
    drive(0, 0, 16'h0, 1);
    tick();
    check("rej_fill", 32'(FILL_LEVEL), 32'd6);
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    check("clr_drop", 32'(FRAME_DROP_CNT), 32'd0);
    check("clr_ovf",  32'(OVERFLOW),       32'd0);
    drain();
    exp_q = '{32'hAA550002, 32'h00010002, 32'h00030004, 32'h00050006,
              32'h00070008, 32'hEE000004};
    compare_words("full");

    // Abort by a second FRAME_START; a sample during BUSY is discarded
    drive(1, 0, 16'h0, 0);
    drive(0, 1, 16'h000A, 0);
    drive(0, 1, 16'h000B, 0);
    drive(1, 0, 16'h0, 0);
    check("abort_busy", 32'(BUSY), 32'd1);
    drive(0, 1, 16'h0BAD, 0);
    check("abort_idle", 32'(BUSY), 32'd0);
    drain();
    exp_q = '{32'hAA550003, 32'h000A000B, 32'hEE010001};
    compare_words("abort");

    // Reset in the middle of a frame with 5 words stored
    DATA_FIFO_RDREQ = 1'b0;
    drive(1, 0, 16'h0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 16'(i), 0);
    check("mid_fill", 32'(FILL_LEVEL), 32'd5);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_empty", 32'(DATA_FIFO_EMPTY), 32'd1);
    check("mid_rst_fill",  32'(FILL_LEVEL),      32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    drive(1, 0, 16'h0, 0);
    drive(0, 1, 16'h0005, 0);
    drive(0, 1, 16'h0006, 0);
    drive(0, 0, 16'h0, 1);
    drain();
    exp_q = '{32'hAA550000, 32'h00050006, 32'hEE000001};
    compare_words("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_data_packer.md
Name: event_data_packer

Overview:
- Producer for the control interface's FWFT data FIFO port (DATA_FIFO_Q / DATA_FIFO_EMPTY / DATA_FIFO_RDREQ).
- Accepts framed 16-bit samples from user logic and packs them in pairs into 32-bit words.
- Wraps each frame in a header word and a trailer word, and buffers the result in an internal single-clock FWFT FIFO.
- The control interface drains the FIFO over TCP. CLK is the same net that drives DATA_FIFO_RDCLK.

Parameters:
DEPTH_LOG2, 9, FIFO depth = 2**DEPTH_LOG2 32-bit words
HDR_TAG, 16'hAA55, upper half of the header word

Ports:
CLK  input  1  single clock, shared with the control interface data-FIFO read clock
RESET_N  input  1  asynchronous, active-low reset
ENABLE  input  1  from CONFIG_REG; when low, FRAME_START is ignored
CLR_STATUS  input  1  one-cycle pulse from PULSE_REG; clears status counters
FRAME_START  input  1  one-cycle pulse; opens a frame
SAMPLE  input  16  sample data
SAMPLE_VALID  input  1  SAMPLE is valid this cycle
FRAME_END  input  1  one-cycle pulse; closes the frame
BUSY  output  1  samples presented while high are dropped
DATA_FIFO_Q  output  32  FWFT head word
DATA_FIFO_EMPTY  output  1  FIFO empty
DATA_FIFO_RDREQ  input  1  pops the head word
FILL_LEVEL  output  DEPTH_LOG2+1  words currently stored
FRAME_DROP_CNT  output  16  frames rejected for lack of space, saturating
OVERFLOW  output  1  sticky; a sample or frame was lost

Behaviour:
- Reset: all outputs 0 except DATA_FIFO_EMPTY=1; FIFO flushed; frame_number=0; state IDLE. Reset asserted mid-frame discards the partial frame, with no trailer.
- Word formats:
  - Header = {HDR_TAG, frame_number[15:0]}.
  - Data = {first sample, second sample}.
  - Trailer = {8'hEE, flags[7:0], data_word_count[15:0]}; flags bit0 ABORT, bit1 DROPPED, bit2 ODD_PAD, others 0.
- At most one FIFO write per cycle. free = depth - FILL_LEVEL, evaluated before the same-cycle write and pop.
- States:
  - IDLE: FRAME_START & ENABLE & free>=3 → write header, frame_number++ (wraps), clear count/flags/half-register, go to DATA. If free<3, FRAME_DROP_CNT++ (saturating), OVERFLOW=1, stay in IDLE. Samples in IDLE are ignored and not counted.
  - DATA, SAMPLE_VALID:
    - With no pending half: latch SAMPLE into the half-register.
    - With a pending half: write a data word if free>=2 (one slot is always reserved for the trailer) and count<16'hFFFF, then count++. Otherwise drop the word, set DROPPED and OVERFLOW.
  - DATA, FRAME_END (the same-cycle sample is processed first): go to PAD if a half is pending, else to TRL.
  - DATA, FRAME_START: set ABORT, go to PAD/TRL as for FRAME_END. The new frame is not opened.
  - PAD (BUSY=1): write {half, 16'h0000} under the same free/count rules, set ODD_PAD, go to TRL.
  - TRL (BUSY=1): write trailer (space is guaranteed), go to IDLE.
- FIFO:
  - DATA_FIFO_EMPTY deasserts the cycle after the first write into an empty FIFO.
  - RDREQ while empty is ignored.
  - Simultaneous read and write keep FILL_LEVEL unchanged.
  - Pointers wrap modulo depth.
- CLR_STATUS zeroes FRAME_DROP_CNT and OVERFLOW. If an increment event occurs in the same cycle, the clear wins.

Optional Feature:
TIMESTAMP_EN
- Defined: a 32-bit free-running counter (reset 0, wraps) is added.
  - State TS (BUSY=1) is inserted between IDLE and DATA and writes the counter value latched at FRAME_START.
  - The header admission threshold becomes free>=4.
- Undefined: no counter, no TS state; header threshold stays 3.

Decomposition:
- Shared package: word-tag constants (HDR_TAG default, 8'hEE trailer tag), flag bit indices, state encoding.
- Sub-module: event_packer_fifo_fwft, a single-clock FWFT FIFO with FILL_LEVEL output, parameterised by DEPTH_LOG2.

Test Plan:
- Frame of 4 samples 0x0001..0x0004, RDREQ held high → words AA550000, 00010002, 00030004, EE000002; EMPTY high afterwards.
- Frame of 3 samples 0x1111, 0x2222, 0x3333 → AA550001, 11112222, 33330000, EE040002.
- DEPTH_LOG2=3, no reads, two 8-sample frames:
  - Frame 1 → header, 4 data words, trailer; FILL_LEVEL=6.
  - Frame 2 → FRAME_DROP_CNT=1, OVERFLOW=1.
  - CLR_STATUS pulse → FRAME_DROP_CNT=0, OVERFLOW=0.
- FRAME_START mid-frame after 2 samples → trailer EE010001 and no new header; a sample sent during BUSY is absent from the output.
- RESET_N low mid-frame with 5 words stored → EMPTY=1, FILL_LEVEL=0; the next frame header reads AA550000.
- With TIMESTAMP_EN, FRAME_START at counter value 0x00000064 → second word 00000064; free=3 rejects the frame.
